zion_riscv_div_exec: RTL and testbench
======================================

Name: zion_riscv_div_exec

Overview:
- Iterative RV32M divide/remainder execution unit: DIV, DIVU, REM, REMU.
- Consumes operands from the issue side and returns one result word over a valid/ready handshake.
- Sits beside the single-cycle add/sub execution unit in the integer execute stage.
- Uses one restoring subtract step per cycle, so it reuses the add/sub datapath style without a combinational divider.

Parameters:
- CPU_WIDTH, 32, operand and result width (32 for RV32, 64 for RV64).
- CNT_W, $clog2(CPU_WIDTH+1), iteration counter width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  abort current operation; pipeline kill.
- in_vld  in  1  request valid.
- in_rdy  out  1  unit can accept a request.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- s1  in  CPU_WIDTH  dividend.
- s2  in  CPU_WIDTH  divisor.
- out_vld  out  1  result valid.
- out_rdy  in  1  consumer accepts result.
- rslt  out  CPU_WIDTH  quotient or remainder.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: in_rdy=1, out_vld=0, rslt=0, busy=0, state=IDLE, counter=0. rst has priority over everything.
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst). Both are fixed.
- Accept: handshake when in_vld & in_rdy on an edge T. in_rdy=1 only in IDLE. op, s1 and s2 are registered at T; inputs are don't-care afterwards.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- PREP (cycle T+1):
  - Signed ops (op[0]=0) take absolute values; record quotient sign = s1[MSB]^s2[MSB] and remainder sign = s1[MSB].
  - Unsigned ops use operands as-is.
  - Detect div-by-zero (s2==0) and signed overflow (s1 = most-negative value, s2 = all ones).
- CALC (T+2 .. T+CPU_WIDTH+1):
  - Exactly CPU_WIDTH restoring steps.
  - Each step: shift partial remainder left and bring in the next dividend MSB. Compute trial = rem − divisor at CPU_WIDTH+1 bits. If non-negative, keep trial and shift in quotient bit 1, else shift in 0.
  - Counter decrements from CPU_WIDTH−1 to 0.
- FIX (T+CPU_WIDTH+2): apply signs by two's-complement negation of quotient and/or remainder. Select quotient (op[1]=0) or remainder (op[1]=1) into rslt.
- DONE: out_vld=1 from T+CPU_WIDTH+3. rslt is held stable until out_vld & out_rdy, then the unit returns to IDLE next cycle. Nominal latency is 35 cycles for RV32.
- Back-to-back: in_rdy rises in the cycle after the output handshake. Accept and output never coincide.
- Div-by-zero: quotient = all ones for both signed and unsigned; remainder = s1.
- Signed overflow: quotient = s1 (most-negative value); remainder = 0.
- Special cases force the result in FIX and bypass the computed value; CALC still runs unless the optional feature is enabled.
- Stalled output: out_rdy low holds DONE indefinitely with no change to rslt.
- flush: in any non-IDLE state, the next state is IDLE with out_vld=0 and in_rdy=1 next cycle. Any pending DONE result is discarded. flush in IDLE with in_vld high blocks acceptance. flush is lower priority than rst.
- rst mid-operation: every output returns to its reset value next cycle and no result is produced.

Optional Feature:
- Macro: ZION_RISCV_DIV_FAST_PATH_EN.
- Defined: PREP goes directly to DONE, with out_vld at T+2, for div-by-zero, signed overflow, |s1| < |s2| (quotient 0, remainder = s1), and s2 magnitude = 1 (quotient = signed/unsigned s1, remainder 0).
- Undefined: every op takes the fixed CPU_WIDTH+3 cycle latency. Results are identical in both builds; only timing differs.

Decomposition:
- Shared ZionRiscvIsaLib package holds:
  - typedef enum logic [1:0] DivOp_e {DIV, DIVU, REM, REMU};
  - typedef enum state type DivState_e {IDLE, PREP, CALC, FIX, DONE};
  - the interface macros for DivEx, mirroring the existing add/sub exec interface.
- One combinational sub-module, zion_riscv_div_step, implements a single restoring iteration: inputs rem, divisor, dividend bit; outputs new rem and quotient bit.

Test Plan:
- DIVU s1=100, s2=7 -> rslt=14, out_vld at 35 cycles after accept (fast path off); REMU same operands -> rslt=2.
- DIV s1=−7 (0xFFFFFFF9), s2=2 -> 0xFFFFFFFD (−3); REM same operands -> 0xFFFFFFFF (−1).
- DIV s1=0x80000000, s2=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIVU s1=0x1234, s2=0 -> 0xFFFFFFFF; REM s1=0x1234, s2=0 -> 0x1234. With the fast path enabled, out_vld at T+2.
- Hold out_rdy=0 for 10 cycles in DONE -> rslt stable and in_rdy=0. Then pulse out_rdy with in_vld held high -> second request accepted on the cycle after the output handshake.
- Assert flush at CALC cycle 5 -> out_vld never rises and in_rdy=1 next cycle. Then assert rst mid-CALC -> all outputs at reset values next cycle. Finish with a 1000-op random regression against a $signed/$unsigned reference model.

Source files
------------

// File: rtl/zion_riscv_div_exec_pkg.sv
// Shared types for the RV32M/RV64M iterative divide execution unit.
// Operation encoding matches the op field driven by the issue stage.
package ZionRiscvIsaLib;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } DivOp_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } DivState_e;

    // Issue-side request bundle for the divide unit, laid out like the add/sub unit's.
    typedef struct packed {
        DivOp_e      op;
        logic [31:0] s1;
        logic [31:0] s2;
    } DivExReq32_s;

endpackage

// File: rtl/zion_riscv_div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module zion_riscv_div_step #(
    parameter int CPU_WIDTH = 32
) (
    input  logic [CPU_WIDTH-1:0] i_rem,
    input  logic [CPU_WIDTH-1:0] i_divisor,
    input  logic                 i_dvdBit,
    output logic [CPU_WIDTH-1:0] o_rem,
    output logic                 o_qBit
);

    logic [CPU_WIDTH:0] w_shifted;
    logic [CPU_WIDTH:0] w_trial;

    // rem < divisor on entry, so the trial difference always fits and its MSB is the sign.
    assign w_shifted = {i_rem, i_dvdBit};
    assign w_trial   = w_shifted - {1'b0, i_divisor};
    assign o_qBit    = ~w_trial[CPU_WIDTH];
    assign o_rem     = o_qBit ? w_trial[CPU_WIDTH-1:0] : w_shifted[CPU_WIDTH-1:0];

endmodule

// File: rtl/zion_riscv_div_exec.sv
// Iterative DIV/DIVU/REM/REMU unit, one restoring step per cycle.
// Define ZION_RISCV_DIV_FAST_PATH_EN to let trivial cases skip CALC/FIX.
module zion_riscv_div_exec
    import ZionRiscvIsaLib::*;
#(
    parameter  int CPU_WIDTH = 32,
    localparam int CNT_W     = $clog2(CPU_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [1:0]           op,
    input  logic [CPU_WIDTH-1:0] s1,
    input  logic [CPU_WIDTH-1:0] s2,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [CPU_WIDTH-1:0] rslt,
    output logic                 busy
);

    DivState_e            r_state;
    DivState_e            w_nxtState;
    logic [1:0]           r_op;
    logic [CPU_WIDTH-1:0] r_s1;
    logic [CPU_WIDTH-1:0] r_s2;
    logic [CPU_WIDTH-1:0] r_quo;
    logic [CPU_WIDTH-1:0] r_rem;
    logic [CPU_WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_qNeg;
    logic                 r_rNeg;
    logic                 r_divZero;
    logic                 r_ovf;
    logic [CPU_WIDTH-1:0] r_rslt;

    logic                 w_signed;
    logic                 w_s1Neg;
    logic                 w_s2Neg;
    logic [CPU_WIDTH-1:0] w_absS1;
    logic [CPU_WIDTH-1:0] w_absS2;
    logic                 w_divZero;
    logic                 w_ovf;
    logic [CPU_WIDTH-1:0] w_newRem;
    logic                 w_qBit;
    logic [CPU_WIDTH-1:0] w_quoFix;
    logic [CPU_WIDTH-1:0] w_remFix;
    logic [CPU_WIDTH-1:0] w_fixRslt;

    assign w_signed  = ~r_op[0];
    assign w_s1Neg   = w_signed & r_s1[CPU_WIDTH-1];
    assign w_s2Neg   = w_signed & r_s2[CPU_WIDTH-1];
    assign w_absS1   = w_s1Neg ? -r_s1 : r_s1;
    assign w_absS2   = w_s2Neg ? -r_s2 : r_s2;
    assign w_divZero = (r_s2 == '0);
    assign w_ovf     = w_signed & (r_s1 == {1'b1, {(CPU_WIDTH-1){1'b0}}}) & (r_s2 == '1);

`ifdef ZION_RISCV_DIV_FAST_PATH_EN
    logic                 w_fast;
    logic [CPU_WIDTH-1:0] w_fastRslt;

    // Cases whose answer is known from the operands alone, without iterating.
    always_comb begin
        w_fast     = 1'b1;
        w_fastRslt = '0;
        if (w_divZero) begin
            w_fastRslt = r_op[1] ? r_s1 : '1;
        end else if (w_ovf) begin
            w_fastRslt = r_op[1] ? '0 : r_s1;
        end else if (w_absS1 < w_absS2) begin
            w_fastRslt = r_op[1] ? r_s1 : '0;
        end else if (w_absS2 == CPU_WIDTH'(1)) begin
            w_fastRslt = r_op[1] ? '0 : (w_s2Neg ? -r_s1 : r_s1);
        end else begin
            w_fast = 1'b0;
        end
    end
`endif

    zion_riscv_div_step #(
        .CPU_WIDTH (CPU_WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .i_dvdBit  (r_quo[CPU_WIDTH-1]),
        .o_rem     (w_newRem),
        .o_qBit    (w_qBit)
    );

    assign w_quoFix = r_qNeg ? -r_quo : r_quo;
    assign w_remFix = r_rNeg ? -r_rem : r_rem;

    always_comb begin
        w_fixRslt = r_op[1] ? w_remFix : w_quoFix;
        if (r_divZero) begin
            w_fixRslt = r_op[1] ? r_s1 : '1;
        end else if (r_ovf) begin
            w_fixRslt = r_op[1] ? '0 : r_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxtState;
        end
    end

    // flush overrides every transition; in IDLE it also blocks acceptance.
    always_comb begin
        w_nxtState = r_state;
        case (r_state)
            IDLE: if (in_vld) w_nxtState = PREP;
`ifdef ZION_RISCV_DIV_FAST_PATH_EN
            PREP: w_nxtState = w_fast ? DONE : CALC;
`else
            PREP: w_nxtState = CALC;
`endif
            CALC: if (r_cnt == '0) w_nxtState = FIX;
            FIX:  w_nxtState = DONE;
            DONE: if (out_rdy) w_nxtState = IDLE;
            default: w_nxtState = IDLE;
        endcase
        if (flush) begin
            w_nxtState = IDLE;
        end
    end

    // The quotient register doubles as the dividend shifter: MSB out, quotient bit in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_qNeg    <= 1'b0;
            r_rNeg    <= 1'b0;
            r_divZero <= 1'b0;
            r_ovf     <= 1'b0;
            r_rslt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_vld && !flush) begin
                        r_op <= op;
                        r_s1 <= s1;
                        r_s2 <= s2;
                    end
                end
                PREP: begin
                    r_quo     <= w_absS1;
                    r_divisor <= w_absS2;
                    r_rem     <= '0;
                    r_cnt     <= CNT_W'(CPU_WIDTH - 1);
                    r_qNeg    <= w_s1Neg ^ w_s2Neg;
                    r_rNeg    <= w_s1Neg;
                    r_divZero <= w_divZero;
                    r_ovf     <= w_ovf;
`ifdef ZION_RISCV_DIV_FAST_PATH_EN
                    if (w_fast) begin
                        r_rslt <= w_fastRslt;
                    end
`endif
                end
                CALC: begin
                    r_quo <= {r_quo[CPU_WIDTH-2:0], w_qBit};
                    r_rem <= w_newRem;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    r_rslt <= w_fixRslt;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_rdy  = (r_state == IDLE);
    assign out_vld = (r_state == DONE);
    assign busy    = (r_state != IDLE);
    assign rslt    = r_rslt;

endmodule

// File: tb/tb_zion_riscv_div_exec.sv
// Directed and random checks for zion_riscv_div_exec (RV32 configuration).
// Latencies count rising edges after the accept edge until out_vld is seen high.
module tb_zion_riscv_div_exec;

    localparam int NORM_LAT = 34;
    localparam int MAX_WAIT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [1:0]  op = 2'b00;
    logic [31:0] s1 = '0;
    logic [31:0] s2 = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [31:0] rslt;
    logic        busy;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    zion_riscv_div_exec #(.CPU_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .op      (op),
        .s1      (s1),
        .s2      (s2),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .rslt    (rslt),
        .busy    (busy)
    );

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFFFFFF;
        if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? 32'd0 : a;
        case (o)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        if (o[0]) begin
            ma = longint'({32'd0, a});
            mb = longint'({32'd0, b});
        end else begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end
        return (b == 32'd0) || (ma < mb) || (mb == 1) ||
               (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef ZION_RISCV_DIV_FAST_PATH_EN
        return ref_fast(o, a, b) ? 1 : NORM_LAT;
`else
        return NORM_LAT;
`endif
    endfunction

    // Drives one request, waits (bounded) for the result, captures it, then consumes it.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bit got;
        @(negedge clk);
        in_vld = 1'b1;
        op = o;
        s1 = a;
        s2 = b;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        s1 = $urandom;
        s2 = $urandom;
        op = 2'($urandom_range(0, 3));
        got = 1'b0;
        lat = 0;
        while (!got && lat < MAX_WAIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_vld) got = 1'b1;
        end
        res = rslt;
        if (got) begin
            out_rdy = 1'b1;
            @(posedge clk);
            #1;
            out_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        testsRun += 4;
        if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_rdy got %b want 1", in_rdy); end
        if (out_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_vld got %b want 0", out_vld); end
        if (rslt !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_rslt got %h want 0", rslt); end
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
    endtask

    // Each vector: op, s1, s2, expected result (hand-computed).
    task automatic test_vectors();
        logic [1:0]  vo [12];
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [31:0] ve [12];
        logic [31:0] res;
        int lat;
        vo = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
        va = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000,
               32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'd7, 32'd7};
        vb = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFE};
        ve = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0,
               32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFD, 32'd1};
        for (int i = 0; i < 12; i++) begin
            run_op(vo[i], va[i], vb[i], res, lat);
            testsRun += 2;
            if (res !== ve[i]) begin
                testsFailed++;
                $display("[TB] FAIL vec%0d_rslt op=%0d s1=%h s2=%h got %h want %h", i, vo[i], va[i], vb[i], res, ve[i]);
            end
            if (lat != exp_lat(vo[i], va[i], vb[i])) begin
                testsFailed++;
                $display("[TB] FAIL vec%0d_latency got %0d want %0d", i, lat, exp_lat(vo[i], va[i], vb[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit stable;
        bit rdyLow;
        int n;
        @(negedge clk);
        in_vld = 1'b1; op = 2'b01; s1 = 32'd1000; s2 = 32'd10;
        @(posedge clk);
        #1 in_vld = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_vld && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (!out_vld) begin testsFailed++; $display("[TB] FAIL stall_timeout got out_vld=0 want 1"); end
        stable = 1'b1;
        rdyLow = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rslt !== 32'd100 || out_vld !== 1'b1) stable = 1'b0;
            if (in_rdy !== 1'b0) rdyLow = 1'b0;
        end
        testsRun += 2;
        if (!stable) begin testsFailed++; $display("[TB] FAIL stall_hold got rslt=%h vld=%b want 00000064 1", rslt, out_vld); end
        if (!rdyLow) begin testsFailed++; $display("[TB] FAIL stall_in_rdy got 1 during DONE want 0"); end
        out_rdy = 1'b1;
        in_vld = 1'b1; op = 2'b01; s1 = 32'd50; s2 = 32'd5;
        @(posedge clk);
        #1 out_rdy = 1'b0;
        @(negedge clk);
        testsRun += 2;
        if (out_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_out_vld got %b want 0", out_vld); end
        if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_in_rdy got %b want 1", in_rdy); end
        @(posedge clk);
        #1 in_vld = 1'b0;
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_accept got busy=%b want 1", busy); end
        n = 0;
        while (!out_vld && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (rslt !== 32'd10 || !out_vld) begin testsFailed++; $display("[TB] FAIL b2b_rslt got %h vld=%b want 0000000a 1", rslt, out_vld); end
        out_rdy = 1'b1;
        @(posedge clk);
        #1 out_rdy = 1'b0;
    endtask

    task automatic test_flush();
        bit sawVld;
        @(negedge clk);
        in_vld = 1'b1; op = 2'b01; s1 = 32'd12345; s2 = 32'd11;
        @(posedge clk);
        #1 in_vld = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        testsRun += 3;
        if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_in_rdy got %b want 1", in_rdy); end
        if (out_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_out_vld got %b want 0", out_vld); end
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_busy got %b want 0", busy); end
        sawVld = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_vld) sawVld = 1'b1;
        end
        testsRun++;
        if (sawVld) begin testsFailed++; $display("[TB] FAIL flush_no_result got out_vld=1 want 0"); end
        in_vld = 1'b1; flush = 1'b1; op = 2'b01; s1 = 32'd9; s2 = 32'd3;
        @(posedge clk);
        #1 begin in_vld = 1'b0; flush = 1'b0; end
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_idle_block got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit sawVld;
        @(negedge clk);
        in_vld = 1'b1; op = 2'b00; s1 = 32'hFFFF0000; s2 = 32'd3;
        @(posedge clk);
        #1 in_vld = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        testsRun += 4;
        if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_in_rdy got %b want 1", in_rdy); end
        if (out_vld !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_out_vld got %b want 0", out_vld); end
        if (rslt !== 32'd0) begin testsFailed++; $display("[TB] FAIL rstmid_rslt got %h want 0", rslt); end
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        sawVld = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_vld) sawVld = 1'b1;
        end
        testsRun++;
        if (sawVld) begin testsFailed++; $display("[TB] FAIL rstmid_no_result got out_vld=1 want 0"); end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] want;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            want = ref_div(o, a, b);
            run_op(o, a, b, res, lat);
            testsRun += 2;
            if (res !== want) begin
                testsFailed++;
                $display("[TB] FAIL rand%0d_rslt op=%0d s1=%h s2=%h got %h want %h", i, o, a, b, res, want);
            end
            if (lat != exp_lat(o, a, b)) begin
                testsFailed++;
                $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, lat, exp_lat(o, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
